mseq_stream_packer: RTL and testbench

Downstream stage of the M-sequence generator array. It samples the LANE_NUM parallel one-bit M-sequence outputs once per enabled cycle and packs PACK_NUM consecutive samples into one wide word. Packed words are buffered in a small first-word-fall-through FIFO. The FIFO is drained over a valid/ready stream toward the transmit/storage path. FIFO overrun is reported with a sticky flag and a saturating drop counter.

---
 rtl/mseq_pkg.sv | 38 +++
 rtl/mseq_sync_fifo.sv | 91 +++++++++
 rtl/mseq_stream_packer.sv | 126 ++++++++++++
 tb/tb_mseq_stream_packer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mseq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mseq_pkg
//  Description : Shared constants and helpers for the M-sequence stream
//                packer: default geometry, packed word width, FIFO address
//                and level widths, and a constant-foldable clog2.
//  Revision    : 1.0 - initial release
// ============================================================================
package mseq_pkg;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int mseq_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return result;
    endfunction

    localparam int c_LANE_NUM_DEF   = 16;
    localparam int c_PACK_NUM_DEF   = 2;
    localparam int c_FIFO_DEPTH_DEF = 8;
    localparam int c_CNT_WIDTH_DEF  = 16;

    // Packed word width for the default geometry.
    localparam int c_OUT_WIDTH = c_LANE_NUM_DEF * c_PACK_NUM_DEF;

    // FIFO pointer width and occupancy width (one extra bit so "full" fits).
    localparam int c_FIFO_AW = mseq_clog2(c_FIFO_DEPTH_DEF);
    localparam int c_FIFO_LW = c_FIFO_AW + 1;

endpackage : mseq_pkg
`default_nettype wire

// File: rtl/mseq_sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mseq_sync_fifo
//  Description : First-word-fall-through synchronous FIFO. The head word is
//                presented combinationally whenever the FIFO is non-empty.
//                A push while full is accepted only if a pop happens on the
//                same edge; otherwise it is ignored (the caller accounts for
//                the drop).
//  Ports       : clk      - clock, rising edge
//                rst_n    - synchronous active-low reset
//                i_push   - write i_din
//                i_din    - write data
//                i_pop    - remove head word (ignored when empty)
//                o_dout   - head word, zero while empty
//                o_full   - level == DEPTH
//                o_empty  - level == 0
//                o_level  - occupancy 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module mseq_sync_fifo
    import mseq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_din,
    input  logic                        i_pop,
    output logic [WIDTH-1:0]            o_dout,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [mseq_clog2(DEPTH):0]  o_level
);

    localparam int c_AW = mseq_clog2(DEPTH);
    localparam int c_LW = c_AW + 1;

    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
    localparam logic [c_LW-1:0] c_LVL_ONE  = c_LW'(1);
    localparam logic [c_LW-1:0] c_LVL_FULL = c_LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;

    logic w_push_ok;
    logic w_pop_ok;

    assign w_pop_ok  = i_pop && !o_empty;
    // When full, a simultaneous pop frees the slot being written.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Storage carries no reset; validity is tracked by r_level alone.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_level <= r_level + c_LVL_ONE;
            end else if (w_pop_ok && !w_push_ok) begin
                r_level <= r_level - c_LVL_ONE;
            end
        end
    end

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == c_LVL_FULL);
    assign o_level = r_level;
    // Masked while empty so the output reads zero out of reset.
    assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule : mseq_sync_fifo
`default_nettype wire

// File: rtl/mseq_stream_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mseq_stream_packer
//  Description : Samples LANE_NUM parallel M-sequence bits on each enabled
//                cycle, packs PACK_NUM samples little-endian into one word,
//                buffers words in an FWFT FIFO and drains them over a
//                valid/ready stream. Overrun sets a sticky flag and bumps a
//                saturating drop counter.
//  Ports       : MSEQ_clk       - clock, rising edge
//                MSEQ_rst_n     - synchronous active-low reset
//                PACK_en        - sample PACK_din on this edge
//                PACK_din       - one bit per lane
//                PACK_flush     - push a partially filled word
//                PACK_dout      - FIFO head word
//                PACK_dout_vld  - head word valid
//                PACK_dout_rdy  - consumer ready, pop on vld & rdy
//                PACK_level     - FIFO occupancy
//                PACK_overflow  - sticky drop indicator
//                PACK_drop_cnt  - saturating count of dropped words
//  Revision    : 1.0 - initial release
// ============================================================================
module mseq_stream_packer
    import mseq_pkg::*;
#(
    parameter int LANE_NUM   = c_LANE_NUM_DEF,
    parameter int PACK_NUM   = c_PACK_NUM_DEF,
    parameter int FIFO_DEPTH = c_FIFO_DEPTH_DEF,
    parameter int CNT_WIDTH  = c_CNT_WIDTH_DEF
) (
    input  logic                             MSEQ_clk,
    input  logic                             MSEQ_rst_n,
    input  logic                             PACK_en,
    input  logic [LANE_NUM-1:0]              PACK_din,
    input  logic                             PACK_flush,
    output logic [LANE_NUM*PACK_NUM-1:0]     PACK_dout,
    output logic                             PACK_dout_vld,
    input  logic                             PACK_dout_rdy,
    output logic [mseq_clog2(FIFO_DEPTH):0]  PACK_level,
    output logic                             PACK_overflow,
    output logic [CNT_WIDTH-1:0]             PACK_drop_cnt
);

    localparam int c_OW = LANE_NUM * PACK_NUM;
    // Keep the slot counter at least one bit wide so PACK_NUM=1 still elaborates.
    localparam int c_SW = (PACK_NUM > 1) ? mseq_clog2(PACK_NUM) : 1;

    localparam logic [c_SW-1:0]      c_SLOT_ONE  = c_SW'(1);
    localparam logic [c_SW-1:0]      c_SLOT_LAST = c_SW'(PACK_NUM - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE   = CNT_WIDTH'(1);

    logic [c_SW-1:0]      r_slot;
    logic [c_OW-1:0]      r_word;
    logic                 r_overflow;
    logic [CNT_WIDTH-1:0] r_drop_cnt;

    logic [c_OW-1:0]      w_word_next;
    logic                 w_last;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    // Partial word with the current sample merged in. Slots above the
    // current one are still zero, which gives flush its zero padding.
    always_comb begin
        w_word_next = r_word;
        if (PACK_en) begin
            w_word_next[r_slot*LANE_NUM +: LANE_NUM] = PACK_din;
        end
    end

    assign w_last = PACK_en && (r_slot == c_SLOT_LAST);
    // A flush only pushes when something has been captured (now or earlier);
    // when it coincides with word completion there is still a single push.
    assign w_push = w_last || (PACK_flush && (PACK_en || (r_slot != '0)));
    assign w_pop  = PACK_dout_vld && PACK_dout_rdy;
    assign w_drop = w_push && w_fifo_full && !w_pop;

    always_ff @(posedge MSEQ_clk) begin
        if (!MSEQ_rst_n) begin
            r_slot <= '0;
            r_word <= '0;
        end else if (w_push) begin
            r_slot <= '0;
            r_word <= '0;
        end else if (PACK_en) begin
            r_slot <= r_slot + c_SLOT_ONE;
            r_word <= w_word_next;
        end
    end

    always_ff @(posedge MSEQ_clk) begin
        if (!MSEQ_rst_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + c_CNT_ONE;
            end
        end
    end

    mseq_sync_fifo #(
        .WIDTH (c_OW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (MSEQ_clk),
        .rst_n   (MSEQ_rst_n),
        .i_push  (w_push),
        .i_din   (w_word_next),
        .i_pop   (w_pop),
        .o_dout  (PACK_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (PACK_level)
    );

    assign PACK_dout_vld = !w_fifo_empty;
    assign PACK_overflow = r_overflow;
    assign PACK_drop_cnt = r_drop_cnt;

endmodule : mseq_stream_packer
`default_nettype wire

// File: tb/tb_mseq_stream_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mseq_stream_packer
//  Description : Self-checking bench for mseq_stream_packer. Expected words
//                are queued when stimulus completes them and compared as the
//                DUT hands them out. A second instance with a 2-bit drop
//                counter shares the stimulus to exercise saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mseq_stream_packer;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] din;
    logic        flush;
    logic        rdy;

    logic [31:0] dout;
    logic        vld;
    logic [3:0]  level;
    logic        ovf;
    logic [15:0] drop;

    logic [31:0] sat_dout;
    logic        sat_vld;
    logic [3:0]  sat_level;
    logic        sat_ovf;
    logic [1:0]  sat_drop;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;

    typedef struct {
        logic        en;
        logic [15:0] din;
        logic        flush;
        logic        push;
        logic [31:0] word;
    } vec_t;
    vec_t vecs[$];

    mseq_stream_packer #(
        .LANE_NUM   (16),
        .PACK_NUM   (2),
        .FIFO_DEPTH (8),
        .CNT_WIDTH  (16)
    ) u_dut (
        .MSEQ_clk      (clk),
        .MSEQ_rst_n    (rst_n),
        .PACK_en       (en),
        .PACK_din      (din),
        .PACK_flush    (flush),
        .PACK_dout     (dout),
        .PACK_dout_vld (vld),
        .PACK_dout_rdy (rdy),
        .PACK_level    (level),
        .PACK_overflow (ovf),
        .PACK_drop_cnt (drop)
    );

    mseq_stream_packer #(
        .LANE_NUM   (16),
        .PACK_NUM   (2),
        .FIFO_DEPTH (8),
        .CNT_WIDTH  (2)
    ) u_dut_sat (
        .MSEQ_clk      (clk),
        .MSEQ_rst_n    (rst_n),
        .PACK_en       (en),
        .PACK_din      (din),
        .PACK_flush    (flush),
        .PACK_dout     (sat_dout),
        .PACK_dout_vld (sat_vld),
        .PACK_dout_rdy (rdy),
        .PACK_level    (sat_level),
        .PACK_overflow (sat_ovf),
        .PACK_drop_cnt (sat_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input int k);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = 16'h1000 + 16'(k);
        hi = 16'h2000 + 16'(k);
        return {hi, lo};
    endfunction

    task automatic push_word(input int k);
        logic [31:0] w;
        w   = mk(k);
        en  = 1'b1;
        din = w[15:0];
        tick();
        din = w[31:16];
        tick();
        en  = 1'b0;
    endtask

    task automatic add(input logic e, input logic [15:0] d, input logic f,
                       input logic p, input logic [31:0] w);
        vec_t v;
        v.en = e; v.din = d; v.flush = f; v.push = p; v.word = w;
        vecs.push_back(v);
    endtask

    // Let every queued word come out; a stuck stream shows up as pending words.
    task automatic drain(input string name);
        rdy = 1'b1;
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) tick();
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: a word seen with vld & rdy between edges is popped next edge.
    always @(negedge clk) begin
        if (rst_n && vld && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h expected none", dout);
            end else begin
                exp_w = exp_q.pop_front();
                check("sb_word", {32'h0, dout}, {32'h0, exp_w});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; din = '0; flush = 1'b0; rdy = 1'b0;
        tick();
        tick();
        check("rst_dout",     64'(dout),     64'd0);
        check("rst_vld",      64'(vld),      64'd0);
        check("rst_level",    64'(level),    64'd0);
        check("rst_overflow", 64'(ovf),      64'd0);
        check("rst_drop",     64'(drop),     64'd0);
        check("rst_sat_drop", 64'(sat_drop), 64'd0);
        rst_n = 1'b1;
        tick();

        // Two captures, word visible the cycle after the second one.
        rdy = 1'b1;
        en  = 1'b1; din = 16'h0001;
        tick();
        check("t1_vld_after_first", 64'(vld), 64'd0);
        din = 16'h8000;
        exp_q.push_back(32'h8000_0001);
        tick();
        en = 1'b0;
        check("t1_vld",   64'(vld),   64'd1);
        check("t1_dout",  64'(dout),  64'h8000_0001);
        check("t1_level", 64'(level), 64'd1);
        tick();
        check("t1_level_after_pop", 64'(level), 64'd0);
        check("t1_vld_after_pop",   64'(vld),   64'd0);

        // Overrun: 20 words into a depth-8 FIFO with the consumer stalled.
        rdy = 1'b0;
        for (int k = 0; k < 20; k++) begin
            push_word(k);
            if (k < 8) exp_q.push_back(mk(k));
            if (k == 7) begin
                check("t2_level_full", 64'(level), 64'd8);
                check("t2_ovf_before", 64'(ovf),   64'd0);
            end
            if (k == 8) begin
                check("t2_ovf_first_drop",  64'(ovf),  64'd1);
                check("t2_drop_first_drop", 64'(drop), 64'd1);
            end
            if (k == 17) begin
                check("t2_drop_10",     64'(drop),     64'd10);
                check("t2_sat_drop_10", 64'(sat_drop), 64'd3);
            end
        end
        check("t2_level",     64'(level),     64'd8);
        check("t2_drop",      64'(drop),      64'd12);
        check("t2_sat_drop",  64'(sat_drop),  64'd3);
        check("t2_sat_ovf",   64'(sat_ovf),   64'd1);
        check("t2_sat_level", 64'(sat_level), 64'd8);
        check("t2_sat_vld",   64'(sat_vld),   64'd1);
        check("t2_sat_head",  64'(sat_dout),  64'(mk(0)));
        drain("t2_pending");
        check("t2_level_drained", 64'(level), 64'd0);
        check("t2_ovf_sticky",    64'(ovf),   64'd1);

        // Full FIFO, push and pop on the same edge: no drop, level holds.
        rdy = 1'b0;
        for (int k = 100; k < 108; k++) begin
            push_word(k);
            exp_q.push_back(mk(k));
        end
        check("t3_level_full", 64'(level), 64'd8);
        exp_w = mk(108);
        en  = 1'b1; din = exp_w[15:0];
        tick();
        din = exp_w[31:16];
        rdy = 1'b1;
        exp_q.push_back(mk(108));
        tick();
        en  = 1'b0;
        rdy = 1'b0;
        check("t3_level_same", 64'(level), 64'd8);
        check("t3_drop_same",  64'(drop),  64'd12);
        drain("t3_pending");
        check("t3_level_drained", 64'(level), 64'd0);

        // Table: flush, gaps, flush/en interactions.
        add(1'b1, 16'h00AA, 1'b0, 1'b0, 32'h0);
        add(1'b0, 16'h0000, 1'b1, 1'b1, 32'h0000_00AA);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 32'h0);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 32'h0);
        add(1'b1, 16'h1234, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) add(1'b0, 16'h0000, 1'b0, 1'b0, 32'h0);
        add(1'b1, 16'hABCD, 1'b0, 1'b1, 32'hABCD_1234);
        add(1'b1, 16'h1234, 1'b0, 1'b0, 32'h0);
        add(1'b1, 16'hABCD, 1'b0, 1'b1, 32'hABCD_1234);
        add(1'b1, 16'h5555, 1'b1, 1'b1, 32'h0000_5555);
        add(1'b1, 16'h0101, 1'b0, 1'b0, 32'h0);
        add(1'b1, 16'h0202, 1'b1, 1'b1, 32'h0202_0101);
        add(1'b0, 16'hFFFF, 1'b0, 1'b0, 32'h0);
        add(1'b1, 16'h0F0F, 1'b0, 1'b0, 32'h0);
        add(1'b0, 16'hEEEE, 1'b0, 1'b0, 32'h0);
        add(1'b1, 16'hF0F0, 1'b0, 1'b1, 32'hF0F0_0F0F);
        rdy = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            en    = vecs[i].en;
            din   = vecs[i].din;
            flush = vecs[i].flush;
            if (vecs[i].push) exp_q.push_back(vecs[i].word);
            tick();
        end
        en = 1'b0; flush = 1'b0; din = '0;
        drain("tbl_pending");
        tick();
        check("tbl_level", 64'(level), 64'd0);

        // Reset mid-word discards the partial sample.
        rdy = 1'b1;
        en  = 1'b1; din = 16'hFFFF;
        tick();
        rst_n = 1'b0; en = 1'b0;
        tick();
        check("t6_level_in_rst", 64'(level), 64'd0);
        rst_n = 1'b1;
        en = 1'b1; din = 16'h1111;
        tick();
        din = 16'h2222;
        exp_q.push_back(32'h2222_1111);
        tick();
        en = 1'b0;
        drain("t6_pending");
        tick();
        check("t6_overflow", 64'(ovf),      64'd0);
        check("t6_drop",     64'(drop),     64'd0);
        check("t6_sat_drop", 64'(sat_drop), 64'd0);
        check("t6_level",    64'(level),    64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mseq_stream_packer
`default_nettype wire
